// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder frame loader and its reduction core.
package adder_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } loader_state_e;

    // Sum of num_input values of width_in bits needs $clog2(num_input) extra bits.
    function automatic int adder_width_out(input int num_input, input int width_in);
        return width_in + $clog2(num_input);
    endfunction

endpackage

// File: rtl/adder_frame_loader_adder.sv
// MultiInputAdder: parallel reduction of NUM_INPUT samples; the input is registered in the
// first of OUTPUT_DELAY pipeline stages, so dout reflects din OUTPUT_DELAY cycles later.
module MultiInputAdder
    import adder_pkg::*;
#(
    parameter int NUM_INPUT    = 21,
    parameter int WIDTH_IN     = 16,
    parameter int IS_SIGNED    = 0,
    parameter int OUTPUT_DELAY = 3,
    localparam int WIDTH_OUT   = adder_width_out(NUM_INPUT, WIDTH_IN)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din,
    output logic [WIDTH_OUT-1:0]                dout
);

    logic [WIDTH_OUT-1:0]                    sum;
    logic [OUTPUT_DELAY-1:0][WIDTH_OUT-1:0]  pipe_d, pipe_q;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (IS_SIGNED != 0) sum = sum + WIDTH_OUT'($signed(din[i]));
            else                sum = sum + WIDTH_OUT'(din[i]);
        end
    end

    always_comb begin
        pipe_d = pipe_q;
        if (ena) begin
            pipe_d[0] = sum;
            for (int i = 1; i < OUTPUT_DELAY; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign dout = pipe_q[OUTPUT_DELAY-1];

endmodule

// File: rtl/adder_frame_loader.sv
// Packs a serial sample stream into MultiInputAdder's parallel input and returns the sum.
// Optional macro ADDER_FRAME_LOADER_CNT_EN adds the m_count output (samples per frame).
module adder_frame_loader
    import adder_pkg::*;
#(
    parameter int NUM_INPUT    = 21,
    parameter int WIDTH_IN     = 16,
    parameter int IS_SIGNED    = 0,
    parameter int OUTPUT_DELAY = 3,
    localparam int WIDTH_OUT   = adder_width_out(NUM_INPUT, WIDTH_IN),
    localparam int CNT_W       = $clog2(NUM_INPUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH_IN-1:0]   s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_OUT-1:0]  m_data,
    output logic                  m_short
`ifdef ADDER_FRAME_LOADER_CNT_EN
    ,
    output logic [CNT_W-1:0]      m_count
`endif
);

    localparam int DLY_W = $clog2(OUTPUT_DELAY + 1);

    loader_state_e                      state_d, state_q;
    logic [CNT_W-1:0]                   idx_d, idx_q;
    logic [NUM_INPUT-1:0][WIDTH_IN-1:0] vec_d, vec_q;
    logic [DLY_W-1:0]                   dly_d, dly_q;
    logic                               short_d, short_q;
    logic                               s_ready_d, s_ready_q;
    logic                               m_valid_d, m_valid_q;
    logic                               m_short_d, m_short_q;
    logic [WIDTH_OUT-1:0]               m_data_d, m_data_q, sum;
    logic                               accept, last_slot;
`ifdef ADDER_FRAME_LOADER_CNT_EN
    logic [CNT_W-1:0]                   m_count_d, m_count_q;
`endif

    assign accept    = s_valid && s_ready_q;
    assign last_slot = (idx_q == CNT_W'(NUM_INPUT - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vec_d     = vec_q;
        dly_d     = dly_q;
        short_d   = short_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_short_d = m_short_q;
`ifdef ADDER_FRAME_LOADER_CNT_EN
        m_count_d = m_count_q;
`endif
        unique case (state_q)
            FILL: if (accept) begin
                vec_d[idx_q] = s_data;
                idx_d        = idx_q + CNT_W'(1);
                if (last_slot || s_last) begin
                    state_d = WAIT;
                    dly_d   = DLY_W'(OUTPUT_DELAY);
                    short_d = s_last && !last_slot;
                end
            end
            WAIT: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q <= DLY_W'(1)) begin
                    state_d   = HOLD;
                    m_valid_d = 1'b1;
                    m_data_d  = sum;
                    m_short_d = short_q;
`ifdef ADDER_FRAME_LOADER_CNT_EN
                    // idx has already counted every accepted sample of the frame
                    m_count_d = idx_q;
`endif
                end
            end
            HOLD: if (m_ready) begin
                state_d   = FILL;
                m_valid_d = 1'b0;
                vec_d     = '0;
                idx_d     = '0;
            end
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            vec_q     <= '0;
            dly_q     <= '0;
            short_q   <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_short_q <= 1'b0;
`ifdef ADDER_FRAME_LOADER_CNT_EN
            m_count_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vec_q     <= vec_d;
            dly_q     <= dly_d;
            short_q   <= short_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_short_q <= m_short_d;
`ifdef ADDER_FRAME_LOADER_CNT_EN
            m_count_q <= m_count_d;
`endif
        end
    end

    // Feeding the next-state vector lets the adder's input stage load on the closing edge,
    // so the sum is ready exactly when the delay counter expires.
    MultiInputAdder #(
        .NUM_INPUT   (NUM_INPUT),
        .WIDTH_IN    (WIDTH_IN),
        .IS_SIGNED   (IS_SIGNED),
        .OUTPUT_DELAY(OUTPUT_DELAY)
    ) u_adder (
        .clk (clk),
        .rst (rst),
        .ena (1'b1),
        .din (vec_d),
        .dout(sum)
    );

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_short = m_short_q;
`ifdef ADDER_FRAME_LOADER_CNT_EN
    assign m_count = m_count_q;
`endif

endmodule

// File: tb/tb_adder_frame_loader.sv
// Directed bench for adder_frame_loader: unsigned and signed instances share one stimulus stream.
module tb_adder_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;
    logic        s_ready, m_valid, m_short;
    logic        s_ready_s, m_valid_s, m_short_s;
    logic [20:0] m_data, m_data_s;
`ifdef ADDER_FRAME_LOADER_CNT_EN
    logic [4:0]  m_count, m_count_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adder_frame_loader #(.NUM_INPUT(21), .WIDTH_IN(16), .IS_SIGNED(0), .OUTPUT_DELAY(3)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_short(m_short)
`ifdef ADDER_FRAME_LOADER_CNT_EN
        , .m_count(m_count)
`endif
    );

    adder_frame_loader #(.NUM_INPUT(21), .WIDTH_IN(16), .IS_SIGNED(1), .OUTPUT_DELAY(3)) dut_s (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s), .m_short(m_short_s)
`ifdef ADDER_FRAME_LOADER_CNT_EN
        , .m_count(m_count_s)
`endif
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        while (!s_ready && n < 50) begin step(); n++; end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, want 1", n);
        end
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!m_valid && cyc < 100) begin step(); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_tests++; if (m_data !== 21'd0) begin n_fail++; $display("FAIL rst_m_data: got %0d want 0", m_data); end
        n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL rst_m_short: got %b want 0", m_short); end
`ifdef ADDER_FRAME_LOADER_CNT_EN
        n_tests++; if (m_count !== 5'd0) begin n_fail++; $display("FAIL rst_m_count: got %0d want 0", m_count); end
`endif
        rst = 1'b0;
        step();
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rel_s_ready: got %b want 1", s_ready); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rel_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_full_unsigned();
        int cyc;
        m_ready = 1'b1;
        for (int i = 0; i < 21; i++) push(16'hFFFF, 1'b0);
        wait_valid(cyc);
        n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL full_latency: got %0d cycles want 3", cyc); end
        n_tests++; if (m_data !== 21'd1376235) begin n_fail++; $display("FAIL full_data: got %0d want 1376235", m_data); end
        n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL full_short: got %b want 0", m_short); end
        step();
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop: m_valid got %b want 0", m_valid); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_rearm: s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_signed();
        int cyc;
        m_ready = 1'b1;
        for (int i = 0; i < 21; i++) push(16'hFFFF, 1'b0);
        wait_valid(cyc);
        n_tests++; if (m_valid_s !== 1'b1) begin n_fail++; $display("FAIL sgn_valid: got %b want 1", m_valid_s); end
        n_tests++; if (m_data_s !== 21'h1FFFEB) begin n_fail++; $display("FAIL sgn_data: got %h want 1fffeb", m_data_s); end
        n_tests++; if (m_short_s !== 1'b0) begin n_fail++; $display("FAIL sgn_short: got %b want 0", m_short_s); end
        step();
    endtask

    task automatic test_short();
        int cyc;
        m_ready = 1'b1;
        push(16'd1, 1'b0); push(16'd2, 1'b0); push(16'd3, 1'b1);
        wait_valid(cyc);
        n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL short_latency: got %0d cycles want 3", cyc); end
        n_tests++; if (m_data !== 21'd6) begin n_fail++; $display("FAIL short_data: got %0d want 6", m_data); end
        n_tests++; if (m_short !== 1'b1) begin n_fail++; $display("FAIL short_flag: got %b want 1", m_short); end
        n_tests++; if (m_data_s !== 21'd6) begin n_fail++; $display("FAIL short_sdata: got %0d want 6", m_data_s); end
`ifdef ADDER_FRAME_LOADER_CNT_EN
        n_tests++; if (m_count !== 5'd3) begin n_fail++; $display("FAIL short_count: got %0d want 3", m_count); end
`endif
        step();
        // s_last on the final slot is a normal full frame
        for (int i = 1; i <= 21; i++) push(16'(i), i == 21);
        wait_valid(cyc);
        n_tests++; if (m_data !== 21'd231) begin n_fail++; $display("FAIL lastslot_data: got %0d want 231", m_data); end
        n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL lastslot_short: got %b want 0", m_short); end
`ifdef ADDER_FRAME_LOADER_CNT_EN
        n_tests++; if (m_count !== 5'd21) begin n_fail++; $display("FAIL lastslot_count: got %0d want 21", m_count); end
`endif
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        m_ready = 1'b0;
        for (int i = 0; i < 21; i++) push(16'd100, 1'b0);
        wait_valid(cyc);
        for (int k = 0; k < 10; k++) begin
            n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, m_valid); end
            n_tests++; if (m_data !== 21'd2100) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want 2100", k, m_data); end
            n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL bp_short[%0d]: got %b want 0", k, m_short); end
            n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d]: got %b want 0", k, s_ready); end
            step();
        end
        m_ready = 1'b1;
        step();
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rearm: s_ready got %b want 1", s_ready); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: m_valid got %b want 0", m_valid); end
    endtask

    task automatic test_ignore();
        int cyc;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(16'd1, i == 5);
        s_valid = 1'b1; s_data = 16'h7777; s_last = 1'b1;
        wait_valid(cyc);
        n_tests++; if (m_data !== 21'd5) begin n_fail++; $display("FAIL ign_data: got %0d want 5", m_data); end
        n_tests++; if (m_short !== 1'b1) begin n_fail++; $display("FAIL ign_short: got %b want 1", m_short); end
        repeat (3) step();
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        step();
        for (int i = 1; i <= 21; i++) push(16'(i), 1'b0);
        wait_valid(cyc);
        n_tests++; if (m_data !== 21'd231) begin n_fail++; $display("FAIL ign_next_data: got %0d want 231", m_data); end
        n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL ign_next_short: got %b want 0", m_short); end
`ifdef ADDER_FRAME_LOADER_CNT_EN
        n_tests++; if (m_count !== 5'd21) begin n_fail++; $display("FAIL ign_next_count: got %0d want 21", m_count); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        int  cyc;
        logic seen = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 10; i++) push(16'(i), 1'b0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (m_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_valid: m_valid seen %b want 0", seen); end
        for (int i = 1; i <= 21; i++) push(16'(i), 1'b0);
        wait_valid(cyc);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", m_valid); end
        n_tests++; if (m_data !== 21'd231) begin n_fail++; $display("FAIL rstmid_data: got %0d want 231", m_data); end
        n_tests++; if (m_short !== 1'b0) begin n_fail++; $display("FAIL rstmid_short: got %b want 0", m_short); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_unsigned();
        test_signed();
        test_short();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
